dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_dump_seq.sv | 127 ++++++++++++
 rtl/dmem_arbiter.sv | 75 +++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its dump sequencer.
package dmem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_e;

  localparam int                      STALL_CNT_W   = 16;
  localparam logic [STALL_CNT_W-1:0]  STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/dmem_dump_seq.sv
// Dump sequencer: walks data memory word by word while the pipeline is halted.
// Optional stall counter enabled by defining DMEM_ARB_STALL_CNT_EN.
module dmem_dump_seq
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_SIZE    = 5,
  parameter int DATA_SIZE    = 32,
  parameter int MEMORY_DEPTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pipe_enable_i,
  input  logic                   dump_start_i,
  input  logic                   dump_ready_i,
  input  logic [DATA_SIZE-1:0]   mem_rdata_i,
  output logic                   dump_rd_o,
  output logic [ADDR_SIZE-1:0]   rd_addr_o,
  output logic [DATA_SIZE-1:0]   dump_data_o,
  output logic [ADDR_SIZE-1:0]   dump_addr_o,
  output logic                   dump_valid_o,
  output logic                   dump_done_o,
  output logic                   busy_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_DEPTH - 1);
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);

  dump_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    data_d    = data_q;
    addr_d    = addr_q;
    case (state_q)
      IDLE: begin
        // A start seen while the pipeline runs is remembered until it halts.
        if ((pending_q || dump_start_i) && !pipe_enable_i) begin
          state_d   = RD;
          pending_d = 1'b0;
        end else if (dump_start_i) begin
          pending_d = 1'b1;
        end
      end
      RD: begin
        if (!pipe_enable_i) state_d = WAIT;
      end
      WAIT: begin
        // Read data reflects the RD-cycle access, whatever the pipe drives now.
        data_d  = mem_rdata_i;
        addr_d  = cnt_q;
        state_d = SEND;
      end
      SEND: begin
        if (dump_ready_i) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + ADDR_ONE;
            state_d = RD;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dump_rd_o    = (state_q == RD) && !pipe_enable_i;
  assign rd_addr_o    = cnt_q;
  assign dump_data_o  = data_q;
  assign dump_addr_o  = addr_q;
  assign dump_valid_o = (state_q == SEND);
  assign dump_done_o  = (state_q == DONE);
  assign busy_o       = pending_q || (state_q != IDLE);

`ifdef DMEM_ARB_STALL_CNT_EN
  logic                   start_dump;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign start_dump = (state_q == IDLE) && (pending_q || dump_start_i) && !pipe_enable_i;

  always_comb begin
    stall_d = stall_q;
    if (start_dump) begin
      stall_d = '0;
    end else if ((state_q == RD) && pipe_enable_i && (stall_q != STALL_CNT_MAX)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline MEM stage vs. debug memory dump.
// Define DMEM_ARB_STALL_CNT_EN to enable the dump stall counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_SIZE    = 5,
  parameter int DATA_SIZE    = 32,
  parameter int MEMORY_DEPTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_pipe_enable,
  input  logic                   i_pipe_mem_read,
  input  logic                   i_pipe_mem_write,
  input  logic [ADDR_SIZE-1:0]   i_pipe_addr,
  input  logic [DATA_SIZE-1:0]   i_pipe_wdata,
  output logic [DATA_SIZE-1:0]   o_pipe_rdata,
  input  logic                   i_dump_start,
  output logic [DATA_SIZE-1:0]   o_dump_data,
  output logic [ADDR_SIZE-1:0]   o_dump_addr,
  output logic                   o_dump_valid,
  input  logic                   i_dump_ready,
  output logic                   o_dump_done,
  output logic                   o_busy,
  output logic [STALL_CNT_W-1:0] o_stall_cnt,
  output logic                   o_mem_enable,
  output logic                   o_mem_write,
  output logic                   o_mem_read,
  output logic [ADDR_SIZE-1:0]   o_mem_addr,
  output logic [DATA_SIZE-1:0]   o_mem_wdata,
  input  logic [DATA_SIZE-1:0]   i_mem_rdata
);

  logic                 dump_rd;
  logic [ADDR_SIZE-1:0] dump_rd_addr;

  dmem_dump_seq #(
    .ADDR_SIZE   (ADDR_SIZE),
    .DATA_SIZE   (DATA_SIZE),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_seq (
    .clk_i        (i_clock),
    .rst_i        (i_reset),
    .pipe_enable_i(i_pipe_enable),
    .dump_start_i (i_dump_start),
    .dump_ready_i (i_dump_ready),
    .mem_rdata_i  (i_mem_rdata),
    .dump_rd_o    (dump_rd),
    .rd_addr_o    (dump_rd_addr),
    .dump_data_o  (o_dump_data),
    .dump_addr_o  (o_dump_addr),
    .dump_valid_o (o_dump_valid),
    .dump_done_o  (o_dump_done),
    .busy_o       (o_busy),
    .stall_cnt_o  (o_stall_cnt)
  );

  // The dump only owns the port in RD while the pipeline is halted.
  always_comb begin
    o_mem_enable = i_pipe_enable;
    o_mem_write  = i_pipe_mem_write;
    o_mem_read   = i_pipe_mem_read;
    o_mem_addr   = i_pipe_addr;
    o_mem_wdata  = i_pipe_wdata;
    if (dump_rd) begin
      o_mem_enable = 1'b1;
      o_mem_write  = 1'b0;
      o_mem_read   = 1'b1;
      o_mem_addr   = dump_rd_addr;
    end
  end

  assign o_pipe_rdata = i_mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a registered data-memory model.
module tb_dmem_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_pipe_enable, i_pipe_mem_read, i_pipe_mem_write;
  logic [AW-1:0] i_pipe_addr;
  logic [DW-1:0] i_pipe_wdata;
  logic [DW-1:0] o_pipe_rdata;
  logic          i_dump_start;
  logic [DW-1:0] o_dump_data;
  logic [AW-1:0] o_dump_addr;
  logic          o_dump_valid, i_dump_ready, o_dump_done, o_busy;
  logic [15:0]   o_stall_cnt;
  logic          o_mem_enable, o_mem_write, o_mem_read;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem [0:DEPTH-1];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEMORY_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_pipe_enable(i_pipe_enable),
    .i_pipe_mem_read(i_pipe_mem_read), .i_pipe_mem_write(i_pipe_mem_write),
    .i_pipe_addr(i_pipe_addr), .i_pipe_wdata(i_pipe_wdata), .o_pipe_rdata(o_pipe_rdata),
    .i_dump_start(i_dump_start), .o_dump_data(o_dump_data), .o_dump_addr(o_dump_addr),
    .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready), .o_dump_done(o_dump_done),
    .o_busy(o_busy), .o_stall_cnt(o_stall_cnt), .o_mem_enable(o_mem_enable),
    .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Registered memory: read data appears one cycle after the read, zero otherwise.
  always @(posedge clk) begin
    if (o_mem_enable && o_mem_write) mem[o_mem_addr] <= o_mem_wdata;
    mem_rdata <= (o_mem_enable && o_mem_read) ? mem[o_mem_addr] : '0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_pipe_enable = 1'b1; i_pipe_mem_write = 1'b1; i_pipe_mem_read = 1'b0;
    i_pipe_addr = 5'd7; i_pipe_wdata = 32'h0000_1234; i_dump_start = 1'b0; i_dump_ready = 1'b0;
    tick; tick;
    vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    vectors++; if (o_dump_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_dump_valid); end
    vectors++; if (o_dump_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_dump_done); end
    vectors++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", o_stall_cnt); end
    vectors++; if (o_dump_data !== 32'd0 || o_dump_addr !== 5'd0) begin
      errors++; $display("FAIL reset_dump_regs: got data %h addr %0d want 0/0", o_dump_data, o_dump_addr); end
    vectors++; if (o_mem_enable !== 1'b1 || o_mem_write !== 1'b1 || o_mem_addr !== 5'd7) begin
      errors++; $display("FAIL reset_passthru: got en %b wr %b addr %0d want 1 1 7", o_mem_enable, o_mem_write, o_mem_addr); end
    i_pipe_mem_write = 1'b0;
    i_reset = 1'b0;
    tick;
  endtask

  task automatic test_passthrough;
    i_pipe_enable = 1'b1; i_pipe_mem_write = 1'b1; i_pipe_addr = 5'd3; i_pipe_wdata = 32'hDEAD_BEEF;
    tick;
    i_pipe_mem_write = 1'b0; i_pipe_mem_read = 1'b1;
    #1;
    vectors++; if (o_mem_read !== 1'b1 || o_mem_addr !== 5'd3 || o_mem_enable !== 1'b1) begin
      errors++; $display("FAIL pass_rd_ctrl: got rd %b addr %0d en %b want 1 3 1", o_mem_read, o_mem_addr, o_mem_enable); end
    tick;
    i_pipe_mem_read = 1'b0;
    vectors++; if (o_pipe_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pass_rdata: got %h want deadbeef", o_pipe_rdata); end
    vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL pass_busy: got %b want 0", o_busy); end
    tick;
    vectors++; if (o_pipe_rdata !== 32'd0) begin errors++; $display("FAIL pass_rdata_idle: got %h want 0", o_pipe_rdata); end
  endtask

  task automatic test_full_dump;
    int cyc;
    int done_cnt;
    int guard;
    logic [DW-1:0] exp;
    i_pipe_enable = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      i_pipe_mem_write = 1'b1; i_pipe_addr = AW'(k); i_pipe_wdata = k * 32'h1111_1111;
      tick;
    end
    i_pipe_mem_write = 1'b0;
    i_pipe_enable = 1'b0; i_dump_ready = 1'b1; i_dump_start = 1'b1;
    tick;
    i_dump_start = 1'b0;
    cyc = 1; done_cnt = 0;
    vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dump_busy: got %b want 1", o_busy); end
    for (int k = 0; k < DEPTH; k++) begin
      guard = 0;
      while (o_dump_valid !== 1'b1 && guard < 10) begin
        tick; cyc++; guard++;
        if (o_dump_done === 1'b1) done_cnt++;
      end
      if (k == 0) begin
        vectors++; if (cyc != 3) begin errors++; $display("FAIL dump_first_latency: got %0d want 3", cyc); end
      end
      exp = k * 32'h1111_1111;
      vectors++; if (o_dump_valid !== 1'b1 || o_dump_addr !== AW'(k) || o_dump_data !== exp) begin
        errors++; $display("FAIL dump_word%0d: got v %b addr %0d data %h want 1 %0d %h",
                           k, o_dump_valid, o_dump_addr, o_dump_data, k, exp); end
      tick;
      if (o_dump_done === 1'b1) done_cnt++;
    end
    vectors++; if (o_dump_done !== 1'b1) begin errors++; $display("FAIL dump_done_pulse: got %b want 1", o_dump_done); end
    tick;
    if (o_dump_done === 1'b1) done_cnt++;
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL dump_done_count: got %0d want 1", done_cnt); end
    vectors++; if (o_busy !== 1'b0) begin errors++; $display("FAIL dump_end_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_backpressure;
    int guard;
    int reads;
    bit stable;
    bit done_seen;
    i_pipe_enable = 1'b0; i_dump_ready = 1'b1; i_dump_start = 1'b1;
    tick;
    i_dump_start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      guard = 0;
      while (o_dump_valid !== 1'b1 && guard < 10) begin tick; guard++; end
      if (k < 5) tick;
    end
    i_dump_ready = 1'b0;
    reads = 0; stable = 1'b1;
    repeat (10) begin
      tick;
      if (o_mem_read === 1'b1) reads++;
      if (o_dump_valid !== 1'b1 || o_dump_data !== 32'h5555_5555 || o_dump_addr !== 5'd5) stable = 1'b0;
    end
    vectors++; if (stable !== 1'b1) begin
      errors++; $display("FAIL bp_stable: got v %b addr %0d data %h want 1 5 55555555", o_dump_valid, o_dump_addr, o_dump_data); end
    vectors++; if (reads != 0) begin errors++; $display("FAIL bp_no_reads: got %0d want 0", reads); end
    i_dump_ready = 1'b1;
    done_seen = 1'b0; guard = 0;
    while (!done_seen && guard < 200) begin
      tick; guard++;
      if (o_dump_done === 1'b1) done_seen = 1'b1;
    end
    vectors++; if (done_seen !== 1'b1) begin errors++; $display("FAIL bp_done: got 0 want 1"); end
    tick;
  endtask

  task automatic test_deferred_preempt;
    bit quiet;
    logic [15:0] exp_stall;
`ifdef DMEM_ARB_STALL_CNT_EN
    exp_stall = 16'd4;
`else
    exp_stall = 16'd0;
`endif
    i_pipe_enable = 1'b1; i_pipe_mem_read = 1'b0; i_dump_ready = 1'b0; i_dump_start = 1'b1;
    tick;
    i_dump_start = 1'b0;
    vectors++; if (o_busy !== 1'b1) begin errors++; $display("FAIL defer_busy: got %b want 1", o_busy); end
    quiet = 1'b1;
    repeat (5) begin
      tick;
      if (o_dump_valid !== 1'b0 || o_mem_read !== 1'b0 || o_busy !== 1'b1) quiet = 1'b0;
    end
    vectors++; if (quiet !== 1'b1) begin
      errors++; $display("FAIL defer_hold: got v %b rd %b busy %b want 0 0 1", o_dump_valid, o_mem_read, o_busy); end
    i_pipe_enable = 1'b0;
    tick;
    i_pipe_enable = 1'b1; i_pipe_mem_read = 1'b1; i_pipe_addr = 5'd3;
    #1;
    vectors++; if (o_mem_addr !== 5'd3 || o_mem_read !== 1'b1 || o_mem_enable !== 1'b1) begin
      errors++; $display("FAIL preempt_route: got addr %0d rd %b en %b want 3 1 1", o_mem_addr, o_mem_read, o_mem_enable); end
    tick;
    i_pipe_mem_read = 1'b0;
    vectors++; if (o_pipe_rdata !== 32'h3333_3333) begin
      errors++; $display("FAIL preempt_rdata: got %h want 33333333", o_pipe_rdata); end
    tick; tick; tick;
    vectors++; if (o_stall_cnt !== exp_stall) begin
      errors++; $display("FAIL preempt_stall_cnt: got %0d want %0d", o_stall_cnt, exp_stall); end
    vectors++; if (o_dump_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL preempt_hold: got v %b busy %b want 0 1", o_dump_valid, o_busy); end
    i_pipe_enable = 1'b0;
    #1;
    vectors++; if (o_mem_read !== 1'b1 || o_mem_write !== 1'b0 || o_mem_addr !== 5'd0 || o_mem_enable !== 1'b1) begin
      errors++; $display("FAIL resume_read: got rd %b wr %b addr %0d en %b want 1 0 0 1",
                         o_mem_read, o_mem_write, o_mem_addr, o_mem_enable); end
    tick; tick;
    vectors++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'd0 || o_dump_data !== 32'd0) begin
      errors++; $display("FAIL resume_word0: got v %b addr %0d data %h want 1 0 0", o_dump_valid, o_dump_addr, o_dump_data); end
  endtask

  task automatic test_reset_mid_dump;
    int guard;
    i_dump_ready = 1'b1;
    guard = 0;
    tick;
    while (!(o_dump_valid === 1'b1 && o_dump_addr === 5'd12) && guard < 100) begin tick; guard++; end
    vectors++; if (o_dump_addr !== 5'd12 || o_dump_valid !== 1'b1) begin
      errors++; $display("FAIL mid_reach12: got addr %0d v %b want 12 1", o_dump_addr, o_dump_valid); end
    i_dump_ready = 1'b0;
    #2;
    i_reset = 1'b1;
    #1;
    vectors++; if (o_dump_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async: got v %b busy %b want 0 0", o_dump_valid, o_busy); end
    vectors++; if (o_dump_addr !== 5'd0 || o_dump_data !== 32'd0 || o_stall_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset_regs: got addr %0d data %h stall %0d want 0 0 0", o_dump_addr, o_dump_data, o_stall_cnt); end
    tick;
    i_reset = 1'b0; i_dump_ready = 1'b1; i_dump_start = 1'b1;
    tick;
    i_dump_start = 1'b0;
    tick; tick;
    vectors++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'd0 || o_dump_data !== 32'd0) begin
      errors++; $display("FAIL restart_word0: got v %b addr %0d data %h want 1 0 0", o_dump_valid, o_dump_addr, o_dump_data); end
    tick; tick; tick;
    vectors++; if (o_dump_valid !== 1'b1 || o_dump_addr !== 5'd1 || o_dump_data !== 32'h1111_1111) begin
      errors++; $display("FAIL restart_word1: got v %b addr %0d data %h want 1 1 11111111", o_dump_valid, o_dump_addr, o_dump_data); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_passthrough;
    test_full_dump;
    test_backpressure;
    test_deferred_preempt;
    test_reset_mid_dump;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
